// File: rtl/vlx_pkg.sv
// Shared definitions for the VLX bit packer/reader pair: FSM states,
// JPEG stuffing/marker bytes, buffer geometry and request normalisation.
package vlx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } vlx_state_e;

  localparam logic [7:0]  MARKER_FF    = 8'hFF;
  localparam logic [7:0]  STUFF_00     = 8'h00;
  localparam logic [31:0] VLX_RST_ADDR = 32'h0383_c1d0;
  localparam int          BUF_W        = 32;
  localparam int          MAX_BITS     = 16;

  // A get-bits count of 0 or anything above MAX_BITS means a full 16-bit read.
  function automatic logic [4:0] norm_bits(input logic [4:0] n);
    return (n == 5'd0 || n > 5'(MAX_BITS)) ? 5'(MAX_BITS) : n;
  endfunction

endpackage

// File: rtl/vlx_bit_buffer.sv
// Right-aligned bit reservoir: bytes shift in at the LSB end, reads take the
// oldest bits first and are padded with 1s when the reservoir runs dry.
module vlx_bit_buffer
  import vlx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        append_i,
  input  logic [7:0]  byte_i,
  input  logic        consume_i,
  input  logic [4:0]  num_i,
  output logic [5:0]  bit_cnt_o,
  output logic [15:0] bits_o
);

  logic [BUF_W-1:0]   bit_reg, bit_next;
  logic [5:0]         cnt_reg, cnt_next;
  logic [5:0]         cnt_after_read;
  logic [2*BUF_W-1:0] padded;
  logic [2*BUF_W-1:0] shifted;
  logic [6:0]         shamt;
  logic [16:0]        mask;

  // Trailing ones under the valid bits provide the padding for short reads.
  assign padded  = {bit_reg, {BUF_W{1'b1}}};
  assign shamt   = 7'(BUF_W) + {1'b0, cnt_reg} - {2'b00, num_i};
  assign shifted = padded >> shamt;
  assign mask    = (17'd1 << num_i) - 17'd1;
  assign bits_o  = shifted[15:0] & mask[15:0];

  assign bit_cnt_o = cnt_reg;

  always_comb begin
    cnt_after_read = cnt_reg;
    if (consume_i)
      cnt_after_read = (cnt_reg >= {1'b0, num_i}) ? cnt_reg - {1'b0, num_i} : 6'd0;
  end

  always_comb begin
    bit_next = bit_reg;
    cnt_next = cnt_after_read;
    if (clr_i) begin
      cnt_next = 6'd0;
    end else if (append_i) begin
      bit_next = {bit_reg[BUF_W-9:0], byte_i};
      cnt_next = cnt_after_read + 6'd8;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_reg <= '0;
      cnt_reg <= 6'd0;
    end else begin
      bit_reg <= bit_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/or1200_vlx_reader.sv
// VLX bit-stream reader: fetches entropy-coded bytes, strips FF 00 stuffing,
// halts on markers and serves 1..16 bits per get-bits instruction.
module or1200_vlx_reader
  import vlx_pkg::*;
#(
  parameter logic [31:0] RST_ADDR = VLX_RST_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        get_bit_op_i,
  input  logic [4:0]  num_bits_i,
  input  logic        spr_cs,
  input  logic        spr_write,
  input  logic [1:0]  spr_addr,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic        stall_cpu_o,
  output logic [31:0] dat_o,
  output logic        done_o,
  output logic        rd_req_o,
  output logic [31:0] vlx_addr_o,
  input  logic        ack_i,
  input  logic [7:0]  rd_dat_i,
  output logic        marker_o
);

  vlx_state_e  state_reg, state_next;
  logic        rd_req_reg, rd_req_next;
  logic [31:0] addr_reg, addr_next;
  logic        ff_seen_reg, ff_seen_next;
  logic        marker_reg, marker_next;
  logic [7:0]  marker_byte_reg, marker_byte_next;
  logic [15:0] dat_reg;
  logic        done_reg;

  logic        addr_wr;
  logic        ack_ok;
  logic        append;
  logic        accept;
  logic [4:0]  n_eff;
  logic [5:0]  bit_cnt;
  logic [15:0] bits;
  logic        unused_spr_addr0;

  assign unused_spr_addr0 = spr_addr[0];
  assign addr_wr = spr_cs & spr_write & spr_addr[1];
  assign n_eff   = norm_bits(num_bits_i);
  // An address write restarts the stream, so an ack landing in that cycle is stale.
  assign ack_ok  = ack_i & rd_req_reg & (state_reg == ST_RUN) & ~addr_wr;
  assign append  = ack_ok & ~ff_seen_reg;
  assign accept  = get_bit_op_i &
                   ((state_reg == ST_HALT) |
                    ((state_reg == ST_RUN) & (bit_cnt >= {1'b0, n_eff})));

  vlx_bit_buffer u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (addr_wr),
    .append_i  (append),
    .byte_i    (rd_dat_i),
    .consume_i (accept),
    .num_i     (n_eff),
    .bit_cnt_o (bit_cnt),
    .bits_o    (bits)
  );

  always_comb begin
    state_next       = state_reg;
    rd_req_next      = rd_req_reg;
    addr_next        = addr_reg;
    ff_seen_next     = ff_seen_reg;
    marker_next      = marker_reg;
    marker_byte_next = marker_byte_reg;
    if (addr_wr) begin
      state_next   = ST_RUN;
      addr_next    = spr_dat_i;
      ff_seen_next = 1'b0;
      marker_next  = 1'b0;
      rd_req_next  = 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (ack_ok) begin
        rd_req_next = 1'b0;
        addr_next   = addr_reg + 32'd1;
        if (!ff_seen_reg) begin
          ff_seen_next = (rd_dat_i == MARKER_FF);
        end else if (rd_dat_i == STUFF_00) begin
          ff_seen_next = 1'b0;
        end else begin
          marker_next      = 1'b1;
          marker_byte_next = rd_dat_i;
          state_next       = ST_HALT;
        end
      end else if (!rd_req_reg && bit_cnt <= 6'd24) begin
        rd_req_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      rd_req_reg      <= 1'b0;
      addr_reg        <= RST_ADDR;
      ff_seen_reg     <= 1'b0;
      marker_reg      <= 1'b0;
      marker_byte_reg <= 8'h00;
      dat_reg         <= 16'h0000;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rd_req_reg      <= rd_req_next;
      addr_reg        <= addr_next;
      ff_seen_reg     <= ff_seen_next;
      marker_reg      <= marker_next;
      marker_byte_reg <= marker_byte_next;
      done_reg        <= accept;
      if (accept)
        dat_reg <= bits;
    end
  end

  assign stall_cpu_o = get_bit_op_i & ~accept;
  assign dat_o       = {16'h0000, dat_reg};
  assign done_o      = done_reg;
  assign rd_req_o    = rd_req_reg;
  assign vlx_addr_o  = addr_reg;
  assign marker_o    = marker_reg;
  assign spr_dat_o   = spr_addr[1] ? addr_reg
                                   : {marker_byte_reg, 14'b0, 2'(state_reg),
                                      ff_seen_reg, 1'b0, bit_cnt};

endmodule
